// File: rtl/fb_loader.sv
// UART-fed framebuffer loader: parses sync/header/data/checksum packets
// and streams pixel bytes into the framebuffer write port.
module fb_loader #(
    parameter int TIMEOUT_CYCLES = 650_000,
    parameter int NUM_ROWS       = 768,
    parameter int ROW_BYTES      = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic [6:0] wx,
    output logic [9:0] wy,
    output logic [7:0] d,
    output logic       we,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, HDR_CNT, DATA, CHK
    } state_t;

    localparam logic [6:0]  LAST_WX = 7'(ROW_BYTES - 1);
    localparam logic [9:0]  LAST_WY = 10'(NUM_ROWS - 1);
    localparam logic [10:0] N_ROWS  = 11'(NUM_ROWS);
    localparam logic [31:0] TMO     = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        prev_q;
    logic [1:0]  hi_q, hi_d;
    logic [9:0]  start_q, start_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  rows_q, rows_d;
    logic [6:0]  wx_q, wx_d;
    logic [9:0]  wy_q, wy_d;
    logic [7:0]  d_q, d_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  xor_q, xor_d;
    logic [31:0] timer_q, timer_d;
    logic        ev;
    logic [9:0]  row;

    assign ev  = rx_ready & ~prev_q;
    assign row = {hi_q, rx_data};

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        d_d     = d_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        xor_d   = xor_q;
        timer_d = (state_q == IDLE) ? 32'd0 : timer_q + 32'd1;
        // The address moves only once the byte has been written out.
        if (we_q) begin
            if (wx_q == LAST_WX) begin
                wx_d   = 7'd0;
                rows_d = rows_q + 9'd1;
                wy_d   = (wy_q == LAST_WY) ? 10'd0 : wy_q + 10'd1;
            end else begin
                wx_d = wx_q + 7'd1;
            end
        end
        if (ev) begin
            timer_d = 32'd0;
        end
        unique case (state_q)
            IDLE: begin
                if (ev && rx_data == 8'hAA) begin
                    state_d = HDR_HI;
                    err_d   = 1'b0;
                end
            end
            HDR_HI: begin
                if (ev) begin
                    hi_d    = rx_data[1:0];
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (ev) begin
                    if ({1'b0, row} >= N_ROWS) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        start_d = row;
                        state_d = HDR_CNT;
                    end
                end
            end
            HDR_CNT: begin
                if (ev) begin
                    cnt_d   = rx_data;
                    wx_d    = 7'd0;
                    wy_d    = start_q;
                    rows_d  = 9'd0;
                    xor_d   = 8'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ev) begin
                    we_d  = 1'b1;
                    d_d   = rx_data;
                    xor_d = xor_q ^ rx_data;
                    if (wx_q == LAST_WX && rows_q == {1'b0, cnt_q}) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (ev) begin
                    if (rx_data == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A byte arriving on the expiry cycle keeps the packet alive.
        if (!ev && state_q != IDLE && timer_q == TMO) begin
            state_d = IDLE;
            err_d   = 1'b1;
            timer_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            hi_q    <= 2'd0;
            start_q <= 10'd0;
            cnt_q   <= 8'd0;
            rows_q  <= 9'd0;
            wx_q    <= 7'd0;
            wy_q    <= 10'd0;
            d_q     <= 8'd0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            xor_q   <= 8'd0;
            timer_q <= 32'd0;
        end else begin
            state_q <= state_d;
            prev_q  <= rx_ready;
            hi_q    <= hi_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            d_q     <= d_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            xor_q   <= xor_d;
            timer_q <= timer_d;
        end
    end

    assign wx   = wx_q;
    assign wy   = wy_q;
    assign d    = d_q;
    assign we   = we_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_fb_loader.sv
// Directed-plus-random bench for fb_loader against a packet-level
// reference model of the expected framebuffer writes.
module tb_fb_loader;

    localparam int T  = 200;
    localparam int NR = 768;
    localparam int RB = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic [6:0] wx;
    logic [9:0] wy;
    logic [7:0] d;
    logic       we;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic we_prev = 1'b0;
    logic [24:0] wq[$];

    fb_loader #(
        .TIMEOUT_CYCLES(T),
        .NUM_ROWS(NR),
        .ROW_BYTES(RB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .wx(wx),
        .wy(wy),
        .d(d),
        .we(we),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wq.push_back({wx, wy, d});
            checks++;
            assert (we_prev !== 1'b1) else begin
                failures++;
                $error("FAIL we_back_to_back observed=1 expected=0");
            end
        end
        we_prev = we;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        rx_ready = 1'b0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic run_packet(input string tag, input int row,
                              input int cnt, input bit bad_chk,
                              input bit with_sync, input bit ramp);
        int n;
        logic [7:0] x;
        logic [7:0] dq[$];
        logic [7:0] hi;
        logic [24:0] e;
        n = (cnt + 1) * RB;
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            dq.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
            x = x ^ dq[i];
        end
        if (bad_chk) x = x ^ 8'h01;
        wq.delete();
        done_cnt = 0;
        hi = 8'(($urandom() & 32'hFC) | 32'(row >> 8));
        if (with_sync) send_byte(8'hAA);
        send_byte(hi);
        send_byte(8'(row));
        send_byte(8'(cnt));
        for (int i = 0; i < n; i++) send_byte(dq[i]);
        send_byte(x);
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            e = {7'(i % RB), 10'((row + i / RB) % NR), dq[i]};
            chk({tag, "_write"}, 32'(wq[i]), 32'(e));
        end
        chk({tag, "_done"}, done_cnt, bad_chk ? 0 : 1);
        chk({tag, "_err"}, err, bad_chk);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int r;
        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", {wx, wy, d}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp row 5: checksum of 0..127 is zero
        run_packet("ramp", 5, 0, 0, 1, 1);

        // Last row wraps to row 0
        run_packet("wrap", NR - 1, 1, 0, 1, 0);

        // Out-of-range start row
        wq.delete();
        done_cnt = 0;
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("badrow_err", err, 1);
        chk("badrow_busy", busy, 0);
        chk("badrow_we", wq.size(), 0);
        send_byte(8'hAA);
        chk("resync_err", err, 0);
        chk("resync_busy", busy, 1);
        repeat (T + 5) @(negedge clk);
        chk("hdr_tmo_err", err, 1);
        chk("hdr_tmo_busy", busy, 0);

        // Bad checksum
        run_packet("badchk", $urandom_range(0, NR - 1), 0, 1, 1, 0);

        // Timeout after 50 data bytes; 0xAA inside payload is data
        wq.delete();
        done_cnt = 0;
        r = $urandom_range(0, NR - 1);
        send_byte(8'hAA);
        send_byte(8'(r >> 8));
        send_byte(8'(r));
        send_byte(8'h00);
        send_byte(8'hAA);
        for (int i = 1; i < 49; i++) send_byte(8'($urandom_range(0, 255)));
        rx_data  = 8'h3C;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (T - 1) @(negedge clk);
        chk("tmo_pre_busy", busy, 1);
        chk("tmo_pre_err", err, 0);
        @(negedge clk);
        chk("tmo_busy", busy, 0);
        chk("tmo_err", err, 1);
        chk("tmo_nwrites", wq.size(), 50);
        chk("tmo_first", 32'(wq[0]), 32'({7'd0, 10'(r), 8'hAA}));
        chk("tmo_last_addr", 32'(wq[49] >> 8), 32'({7'd49, 10'(r)}));
        chk("tmo_done", done_cnt, 0);

        // Reset mid-packet after the 10th data byte
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
        rst = 1'b1;
        @(negedge clk);
        wq.delete();
        done_cnt = 0;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_flags", {done, err}, 0);
        chk("mid_rst_addr", {wx, wy, d}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("post_rst_nwrites", wq.size(), 0);
        chk("post_rst_idle", busy, 0);
        run_packet("after_rst", $urandom_range(0, NR - 1), 0, 0, 1, 0);

        // rx_ready held high across reset release is a sync byte
        rst      = 1'b1;
        rx_ready = 1'b1;
        rx_data  = 8'hAA;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("held_rst_busy", busy, 0);
        @(negedge clk);
        chk("held_evt_busy", busy, 1);
        rx_ready = 1'b0;
        @(negedge clk);
        run_packet("held", $urandom_range(0, NR - 1), 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_loader.md
FB_LOADER -- requirements
Module: fb_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 650_000, meaning max clk cycles allowed between bytes inside a packet (10 ms at 65 MHz).
REQ-002 SHALL have parameter NUM_ROWS, default 768, meaning framebuffer rows; row index range 0..NUM_ROWS-1.
REQ-003 SHALL have parameter ROW_BYTES, default 128, meaning bytes per row (8 pixels/byte, MSB = leftmost).
REQ-004 Port clk  input  1  pixel-domain clock (65 MHz); the single clock.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port rx_ready  input  1  UART byte-ready level; a new byte is signalled by its 0->1 transition.
REQ-007 Port rx_data  input  8  UART byte, valid when rx_ready is high.
REQ-008 Port wx  output  7  framebuffer write column (byte index).
REQ-009 Port wy  output  10  framebuffer write row.
REQ-010 Port d  output  8  framebuffer write data.
REQ-011 Port we  output  1  framebuffer write enable, one-cycle pulse per data byte.
REQ-012 Port busy  output  1  high in any state other than IDLE.
REQ-013 Port done  output  1  one-cycle pulse on packet completion with checksum match.
REQ-014 Port err  output  1  sticky error flag; cleared on the next accepted sync byte or on rst.

Function
REQ-015 SHALL register rx_ready each cycle (prev); a byte event SHALL be rx_ready==1 && prev==0; at most one event per 0->1 transition.
REQ-016 Packet format SHALL be: 0xAA sync, ROW_HI, ROW_LO, COUNT, (COUNT+1)*ROW_BYTES data bytes, CHK.
REQ-017 Start row SHALL be {ROW_HI[1:0], ROW_LO}; ROW_HI[7:2] ignored; rows written = COUNT+1 (1..256).
REQ-018 FSM states SHALL be IDLE, HDR_HI, HDR_LO, HDR_CNT, DATA, CHK.
REQ-019 IDLE: byte 0xAA -> HDR_HI and clear err; any other byte ignored, no state change.
REQ-020 HDR_HI -> HDR_LO -> HDR_CNT on each byte event; HDR_CNT byte -> DATA with wx=0, wy=start row.
REQ-021 HDR_LO: if start row >= NUM_ROWS, SHALL set err and return to IDLE (packet rejected, no writes).
REQ-022 DATA: each byte event SHALL assert we on the next cycle with d=byte, wx/wy = address of that byte; address then advances on the cycle we deasserts-no earlier.
REQ-023 Address advance SHALL be wx+1; at wx==ROW_BYTES-1, wx->0 and wy+1; at wy==NUM_ROWS-1 wy wraps to 0.
REQ-024 SHALL maintain running XOR of all data bytes, cleared on entry to DATA.
REQ-025 After the last data byte (COUNT+1 rows complete) SHALL go to CHK; row counter 9 bits, no overflow.
REQ-026 CHK byte event: match -> done pulse one cycle later; mismatch -> err set; both -> IDLE.
REQ-027 we SHALL be low in every state except the cycle following a DATA byte event; never two consecutive cycles high.
REQ-028 Inter-byte timer SHALL clear on each byte event and count while busy; reaching TIMEOUT_CYCLES SHALL set err and force IDLE; counter idle in IDLE.
REQ-029 Timeout and byte event on the same cycle: byte event wins, timer clears.
REQ-030 0xAA inside header/data/CHK SHALL be treated as payload, not resync.
REQ-031 Writes already issued before a timeout/error SHALL NOT be undone.

Reset
REQ-032 rst SHALL force IDLE, we=0, done=0, err=0, busy=0, wx=0, wy=0, d=0, prev=0, XOR=0, timer=0, within one clk edge.
REQ-033 rst mid-packet SHALL abort without further writes; if rx_ready is high when rst releases, a rising-edge event SHALL be registered one cycle later (prev=0) and treated as a normal byte in IDLE.

Verification
REQ-034 Sync 0xAA,0x00,0x05,0x00, 128 bytes 0x00..0x7F, CHK=0x00 -> 128 we pulses, wy=5, wx 0..127, d=wx, done pulse, err=0.
REQ-035 Row 767, COUNT=1 -> first 128 writes wy=767, next 128 wy=0; done on correct CHK.
REQ-036 Header row 0x03,0x00 (768) -> err=1, busy=0, zero we pulses; next 0xAA clears err.
REQ-037 Full packet with CHK off by one bit -> all writes issued, no done, err=1.
REQ-038 Stop after 50 data bytes, idle TIMEOUT_CYCLES -> exactly 50 we, err=1, busy=0 at TIMEOUT_CYCLES+1 after last event.
REQ-039 Assert rst after 10th data byte -> we stays 0 thereafter, all outputs at reset values; following full packet completes with done.
